reg_writeback: RTL and testbench

Writeback stage feeding the integer register file's single write port (RD/RD_data, which writes every cycle with no enable). It merges single-cycle ALU results and multi-cycle load responses into one registered write per cycle. It sign/zero-extends load data and tracks outstanding loads in a scoreboard. It drives hazard-busy flags and, optionally, bypassed read data back to decode.

---
 rtl/reg_writeback_if.sv | 28 ++
 rtl/reg_writeback.sv | 110 +++++++++++
 tb/tb_reg_writeback.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_writeback_if.sv
// reg_writeback_if: ALU result and load issue/response handshakes into the writeback stage
interface reg_writeback_if #(
    parameter int WIDTH = 32
);
    logic             iAluValid;
    logic [4:0]       iAluRd;
    logic [WIDTH-1:0] iAluData;
    logic             oAluReady;
    logic             iLdIssue;
    logic [4:0]       iLdIssueRd;
    logic             iLdValid;
    logic [4:0]       iLdRd;
    logic [2:0]       iLdSize;
    logic [WIDTH-1:0] iLdData;
    logic             oLdReady;

    modport master (
        output iAluValid, iAluRd, iAluData, iLdIssue, iLdIssueRd,
               iLdValid, iLdRd, iLdSize, iLdData,
        input  oAluReady, oLdReady
    );

    modport slave (
        input  iAluValid, iAluRd, iAluData, iLdIssue, iLdIssueRd,
               iLdValid, iLdRd, iLdSize, iLdData,
        output oAluReady, oLdReady
    );
endinterface

// File: rtl/reg_writeback.sv
// reg_writeback: merges ALU/load results into one registered RF write, tracks pending loads; WB_BYPASS_EN enables decode bypass
module reg_writeback #(
    parameter int WIDTH = 32
) (
    input  logic             iClk,
    input  logic             iRstN,
    reg_writeback_if.slave   bus,
    output logic [4:0]       oRD,
    output logic [WIDTH-1:0] oRD_data,
    input  logic [4:0]       iRs1,
    input  logic [4:0]       iRs2,
    input  logic [WIDTH-1:0] iRs1Data,
    input  logic [WIDTH-1:0] iRs2Data,
    output logic [WIDTH-1:0] oRs1Data,
    output logic [WIDTH-1:0] oRs2Data,
    output logic             oRs1Busy,
    output logic             oRs2Busy
);
    logic             hold_valid_q, hold_valid_d;
    logic [4:0]       hold_rd_q, hold_rd_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic [31:0]      pending_q, pending_d;
    logic [4:0]       rd_q, rd_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             ready, ld_acc, alu_acc;
    logic [4:0]       wr_rd;
    logic [WIDTH-1:0] wr_data, ld_ext;
    logic             hit1, hit2;

    assign ready         = iRstN && !hold_valid_q;
    assign bus.oAluReady = ready;
    assign bus.oLdReady  = ready;
    assign ld_acc        = bus.iLdValid && ready;
    assign alu_acc       = bus.iAluValid && ready;

    // Sign/zero-extend the lane-aligned load data by funct3; unknown codes act as LW
    always_comb begin
        case (bus.iLdSize)
            3'b000:  ld_ext = WIDTH'($signed(bus.iLdData[7:0]));
            3'b001:  ld_ext = WIDTH'($signed(bus.iLdData[15:0]));
            3'b100:  ld_ext = WIDTH'(bus.iLdData[7:0]);
            3'b101:  ld_ext = WIDTH'(bus.iLdData[15:0]);
            default: ld_ext = WIDTH'($signed(bus.iLdData[31:0]));
        endcase
    end

    // Pick this cycle's write (hold > load > ALU), park a colliding ALU result, update the scoreboard
    always_comb begin
        hold_valid_d = 1'b0;
        hold_rd_d    = hold_rd_q;
        hold_data_d  = hold_data_q;
        wr_rd        = '0;
        wr_data      = '0;
        if (hold_valid_q) begin
            wr_rd   = hold_rd_q;
            wr_data = hold_data_q;
        end else if (ld_acc) begin
            wr_rd        = bus.iLdRd;
            wr_data      = ld_ext;
            hold_valid_d = alu_acc;
            hold_rd_d    = bus.iAluRd;
            hold_data_d  = bus.iAluData;
        end else if (alu_acc) begin
            wr_rd   = bus.iAluRd;
            wr_data = bus.iAluData;
        end
        rd_d      = wr_rd;
        rd_data_d = (wr_rd != '0) ? wr_data : '0;
        pending_d = pending_q;
        if (ld_acc) pending_d[bus.iLdRd] = 1'b0;
        if (bus.iLdIssue) pending_d[bus.iLdIssueRd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // State registers; reset drops the hold entry and all outstanding loads
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            hold_valid_q <= 1'b0;
            hold_rd_q    <= '0;
            hold_data_q  <= '0;
            pending_q    <= '0;
            rd_q         <= '0;
            rd_data_q    <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_rd_q    <= hold_rd_d;
            hold_data_q  <= hold_data_d;
            pending_q    <= pending_d;
            rd_q         <= rd_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign oRD      = rd_q;
    assign oRD_data = rd_data_q;
    assign hit1     = (iRs1 == rd_q) && (rd_q != '0);
    assign hit2     = (iRs2 == rd_q) && (rd_q != '0);

`ifdef WB_BYPASS_EN
    assign oRs1Data = hit1 ? rd_data_q : iRs1Data;
    assign oRs2Data = hit2 ? rd_data_q : iRs2Data;
    assign oRs1Busy = pending_q[iRs1] && (iRs1 != '0);
    assign oRs2Busy = pending_q[iRs2] && (iRs2 != '0);
`else
    assign oRs1Data = iRs1Data;
    assign oRs2Data = iRs2Data;
    assign oRs1Busy = (pending_q[iRs1] && (iRs1 != '0)) || hit1;
    assign oRs2Busy = (pending_q[iRs2] && (iRs2 != '0)) || hit2;
`endif
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed stimulus checked every cycle against a queue-based writeback model
module tb_reg_writeback;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] rd_data, rs1_in, rs2_in, rs1_out, rs2_out;
    logic        busy1, busy2;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t         q[$];
    logic [31:0] pend;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;

    always #5 clk = ~clk;

    reg_writeback_if #(.WIDTH(32)) bus ();

    assign rs1_in = 32'h1000_0000 | 32'(rs1);
    assign rs2_in = 32'h2000_0000 | 32'(rs2);

    reg_writeback #(.WIDTH(32)) dut (
        .iClk(clk), .iRstN(rst_n), .bus(bus),
        .oRD(rd), .oRD_data(rd_data),
        .iRs1(rs1), .iRs2(rs2), .iRs1Data(rs1_in), .iRs2Data(rs2_in),
        .oRs1Data(rs1_out), .oRs2Data(rs2_out),
        .oRs1Busy(busy1), .oRs2Busy(busy2)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ext(input logic [2:0] sz, input logic [31:0] d);
        int v;
        case (sz)
            3'd0: begin v = int'(d & 32'hFF);   if (v > 127)   v -= 256;   end
            3'd1: begin v = int'(d & 32'hFFFF); if (v > 32767) v -= 65536; end
            3'd4: v = int'(d & 32'hFF);
            3'd5: v = int'(d & 32'hFFFF);
            default: v = int'(d);
        endcase
        return 32'(v);
    endfunction

    task automatic model_step;
        wr_t w;
        bit  rdy;
        if (!rst_n) begin
            q.delete();
            pend     = '0;
            exp_rd   = '0;
            exp_data = '0;
        end else begin
            rdy = (q.size() == 0);
            if (rdy && bus.iLdValid) begin
                w.rd   = bus.iLdRd;
                w.data = ext(bus.iLdSize, bus.iLdData);
                q.push_back(w);
                pend[bus.iLdRd] = 1'b0;
            end
            if (rdy && bus.iAluValid) begin
                w.rd   = bus.iAluRd;
                w.data = bus.iAluData;
                q.push_back(w);
            end
            if (bus.iLdIssue && bus.iLdIssueRd != 5'd0) pend[bus.iLdIssueRd] = 1'b1;
            if (q.size() > 0) begin
                w        = q.pop_front();
                exp_rd   = w.rd;
                exp_data = (w.rd == 5'd0) ? 32'd0 : w.data;
            end else begin
                exp_rd   = '0;
                exp_data = '0;
            end
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle;
        bus.iAluValid = 1'b0;
        bus.iLdValid  = 1'b0;
        bus.iLdIssue  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("oRD", 32'(rd), 32'(exp_rd));
            cmp("oRD_data", rd_data, exp_data);
            cmp("oAluReady", 32'(bus.oAluReady), 32'(rst_n && q.size() == 0));
            cmp("oLdReady", 32'(bus.oLdReady), 32'(rst_n && q.size() == 0));
`ifdef WB_BYPASS_EN
            cmp("oRs1Busy", 32'(busy1), 32'(pend[rs1] && rs1 != 5'd0));
            cmp("oRs2Busy", 32'(busy2), 32'(pend[rs2] && rs2 != 5'd0));
            cmp("oRs1Data", rs1_out, (rs1 == exp_rd && exp_rd != 5'd0) ? exp_data : rs1_in);
            cmp("oRs2Data", rs2_out, (rs2 == exp_rd && exp_rd != 5'd0) ? exp_data : rs2_in);
`else
            cmp("oRs1Busy", 32'(busy1), 32'((pend[rs1] && rs1 != 5'd0) || (rs1 == exp_rd && exp_rd != 5'd0)));
            cmp("oRs2Busy", 32'(busy2), 32'((pend[rs2] && rs2 != 5'd0) || (rs2 == exp_rd && exp_rd != 5'd0)));
            cmp("oRs1Data", rs1_out, rs1_in);
            cmp("oRs2Data", rs2_out, rs2_in);
`endif
        end
    end

    logic [2:0]  sizes[4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] lexp[4]  = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_80F0, 32'h0000_80F0};

    initial begin
        rst_n          = 1'b0;
        rs1            = 5'd3;
        rs2            = 5'd0;
        bus.iAluValid  = 1'b1;
        bus.iAluRd     = 5'd1;
        bus.iAluData   = 32'h5;
        bus.iLdValid   = 1'b1;
        bus.iLdRd      = 5'd2;
        bus.iLdSize    = 3'd2;
        bus.iLdData    = 32'h9;
        bus.iLdIssue   = 1'b1;
        bus.iLdIssueRd = 5'd3;
        cyc();
        chk_en = 1'b1;
        cyc();
        cmp("rst_oRD", 32'(rd), 32'd0);
        cmp("rst_oRD_data", rd_data, 32'd0);
        cmp("rst_alu_ready", 32'(bus.oAluReady), 32'd0);
        cmp("rst_ld_ready", 32'(bus.oLdReady), 32'd0);
        cmp("rst_busy1", 32'(busy1), 32'd0);
        rst_n = 1'b1;
        idle();
        #1;
        cmp("post_rst_alu_ready", 32'(bus.oAluReady), 32'd1);
        cmp("post_rst_ld_ready", 32'(bus.oLdReady), 32'd1);
        cyc();

        for (int i = 0; i < 4; i++) begin
            bus.iLdValid = 1'b1;
            bus.iLdRd    = 5'd5;
            bus.iLdSize  = sizes[i];
            bus.iLdData  = 32'h0000_80F0;
            cyc();
            cmp("ld_ext_rd", 32'(rd), 32'd5);
            cmp("ld_ext_data", rd_data, lexp[i]);
        end
        idle();
        cyc();

        bus.iAluValid = 1'b1;
        bus.iAluRd    = 5'd3;
        bus.iAluData  = 32'h11;
        bus.iLdValid  = 1'b1;
        bus.iLdRd     = 5'd4;
        bus.iLdSize   = 3'd2;
        bus.iLdData   = 32'h22;
        cyc();
        idle();
        cmp("coll_rd1", 32'(rd), 32'd4);
        cmp("coll_data1", rd_data, 32'h22);
        cmp("coll_alu_ready", 32'(bus.oAluReady), 32'd0);
        cmp("coll_ld_ready", 32'(bus.oLdReady), 32'd0);
        cyc();
        cmp("coll_rd2", 32'(rd), 32'd3);
        cmp("coll_data2", rd_data, 32'h11);
        cyc();
        cmp("coll_idle", 32'(rd), 32'd0);

        bus.iLdIssue   = 1'b1;
        bus.iLdIssueRd = 5'd7;
        cyc();
        idle();
        rs1 = 5'd7;
        #1;
        cmp("sb_busy_issue", 32'(busy1), 32'd1);
        cyc();
        cmp("sb_busy_hold", 32'(busy1), 32'd1);
        bus.iLdValid   = 1'b1;
        bus.iLdRd      = 5'd7;
        bus.iLdSize    = 3'd2;
        bus.iLdData    = 32'h77;
        bus.iLdIssue   = 1'b1;
        bus.iLdIssueRd = 5'd7;
        cyc();
        idle();
        cmp("sb_set_wins", 32'(busy1), 32'd1);
        cyc();
        cmp("sb_still_busy", 32'(busy1), 32'd1);
        bus.iLdValid = 1'b1;
        cyc();
        idle();
`ifdef WB_BYPASS_EN
        cmp("sb_clear_next", 32'(busy1), 32'd0);
`endif
        cyc();
        cmp("sb_cleared", 32'(busy1), 32'd0);
        bus.iLdIssue   = 1'b1;
        bus.iLdIssueRd = 5'd0;
        rs1            = 5'd0;
        cyc();
        idle();
        cmp("sb_x0_busy", 32'(busy1), 32'd0);

        bus.iAluValid = 1'b1;
        bus.iAluRd    = 5'd9;
        bus.iAluData  = 32'hDEAD;
        cyc();
        idle();
        rs2 = 5'd9;
        #1;
`ifdef WB_BYPASS_EN
        cmp("byp_data", rs2_out, 32'hDEAD);
        cmp("byp_busy", 32'(busy2), 32'd0);
`else
        cmp("nobyp_busy", 32'(busy2), 32'd1);
        cmp("nobyp_data", rs2_out, 32'h2000_0009);
`endif
        cyc();
        cmp("byp_after_busy", 32'(busy2), 32'd0);
        cmp("byp_after_data", rs2_out, 32'h2000_0009);

        bus.iLdIssue   = 1'b1;
        bus.iLdIssueRd = 5'd6;
        cyc();
        idle();
        bus.iAluValid = 1'b1;
        bus.iAluRd    = 5'd3;
        bus.iAluData  = 32'h11;
        bus.iLdValid  = 1'b1;
        bus.iLdRd     = 5'd4;
        bus.iLdSize   = 3'd2;
        bus.iLdData   = 32'h22;
        cyc();
        idle();
        cmp("mid_hold_full", 32'(bus.oAluReady), 32'd0);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        rs1   = 5'd6;
        #1;
        cmp("mid_busy6", 32'(busy1), 32'd0);
        cmp("mid_rd_rst", 32'(rd), 32'd0);
        cyc();
        cmp("mid_no_x3", 32'(rd), 32'd0);
        cmp("mid_no_x3_data", rd_data, 32'd0);
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
